// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared widths, size encodings and FSM states for the load/store unit
package lsu_pkg;

   localparam int XLEN = 32;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      STORE,
      RMW_READ,
      RMW_WRITE,
      RESP
   } lsu_state_t;

   // Reserved size counts as an error alongside natural-alignment violations.
   function automatic logic access_error(input logic [1:0] size, input logic [1:0] offset);
      case (size)
         SIZE_B:  access_error = 1'b0;
         SIZE_H:  access_error = offset[0];
         SIZE_W:  access_error = (offset != 2'b00);
         default: access_error = 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - little-endian lane extraction/extension for loads and lane merge for sub-word stores
module lsu_lane_align
   import lsu_pkg::*;
#(
   parameter int W = lsu_pkg::XLEN
) (
   input  logic [1:0]   size,
   input  logic         is_unsigned,
   input  logic [1:0]   offset,
   input  logic [W-1:0] rdata,
   output logic [W-1:0] load_data,
   input  logic [W-1:0] old_word,
   input  logic [W-1:0] store_data,
   output logic [W-1:0] merged
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_lane = rdata[{offset, 3'b000} +: 8];
      half_lane = rdata[{offset[1], 4'b0000} +: 16];
      case (size)
         SIZE_B:  load_data = {{(W-8){~is_unsigned & byte_lane[7]}}, byte_lane};
         SIZE_H:  load_data = {{(W-16){~is_unsigned & half_lane[15]}}, half_lane};
         default: load_data = rdata;
      endcase
   end

   always_comb begin
      merged = old_word;
      case (size)
         SIZE_B:  merged[{offset, 3'b000} +: 8]    = store_data[7:0];
         SIZE_H:  merged[{offset[1], 4'b0000} +: 16] = store_data[15:0];
         default: merged = store_data;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - request FSM driving a word-addressed data memory for byte/half/word loads and stores
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int XLEN = lsu_pkg::XLEN
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [1:0]      req_size,
   input  logic            req_unsigned,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   output logic            rsp_valid,
   output logic [XLEN-1:0] rsp_rdata,
   output logic            rsp_err,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   output logic            mem_we,
   input  logic [XLEN-1:0] mem_rdata
);

   lsu_state_t      state, next_state;
   logic            accept;
   logic [1:0]      size_q;
   logic            uns_q;
   logic [XLEN-1:0] addr_q;
   logic [XLEN-1:0] wdata_q;
   logic [XLEN-1:0] merge_q;
   logic [XLEN-1:0] load_data;
   logic [XLEN-1:0] merged;

   lsu_lane_align #(.W(XLEN)) u_align (
      .size        (size_q),
      .is_unsigned (uns_q),
      .offset      (addr_q[1:0]),
      .rdata       (mem_rdata),
      .load_data   (load_data),
      .old_word    (merge_q),
      .store_data  (wdata_q),
      .merged      (merged)
   );

   // Address register is only reloaded on acceptance, so it holds between requests.
   assign mem_addr = {addr_q[XLEN-1:2], 2'b00};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      mem_we     = 1'b0;
      mem_wdata  = '0;
      rsp_valid  = 1'b0;
      req_ready  = (state == IDLE) && rst_n;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid && rst_n) begin
               accept = 1'b1;
               if (access_error(req_size, req_addr[1:0])) begin
                  next_state = RESP;
               end else if (!req_we) begin
                  next_state = LOAD;
               end else if (req_size == SIZE_W) begin
                  next_state = STORE;
               end else begin
                  next_state = RMW_READ;
               end
            end
         end
         LOAD:     next_state = RESP;
         STORE: begin
            mem_we     = 1'b1;
            mem_wdata  = wdata_q;
            next_state = RESP;
         end
         RMW_READ: next_state = RMW_WRITE;
         RMW_WRITE: begin
            mem_we     = 1'b1;
            mem_wdata  = merged;
            next_state = RESP;
         end
         RESP: begin
            rsp_valid  = 1'b1;
            next_state = IDLE;
         end
         default:  next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         size_q    <= SIZE_B;
         uns_q     <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         merge_q   <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         if (accept) begin
            size_q    <= req_size;
            uns_q     <= req_unsigned;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            rsp_rdata <= '0;
            rsp_err   <= access_error(req_size, req_addr[1:0]);
         end
         if (state == LOAD) begin
            rsp_rdata <= load_data;
         end
         if (state == RMW_READ) begin
            merge_q <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed and randomized checks of load_store_unit against a byte-array memory model
module tb_load_store_unit;

   localparam int NWORDS = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_err, mem_we;
   logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;

   logic [31:0] tb_mem [NWORDS];
   logic [7:0]  ref_bytes [4*NWORDS];

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          wes;
      logic [31:0] waddr;
      int          acc_cyc;
   } exp_t;

   req_t        pend_q[$];
   exp_t        exp_q[$];
   logic [31:0] rsp_log[$];
   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;

   load_store_unit dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_we       (mem_we),
      .mem_rdata    (mem_rdata)
   );

   always #5 clk = ~clk;

   assign mem_rdata = tb_mem[mem_addr[7:2]];
   always @(posedge clk) if (mem_we) tb_mem[mem_addr[7:2]] <= mem_wdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic preload(input logic [31:0] addr, input logic [31:0] word);
      tb_mem[addr[7:2]] = word;
      for (int i = 0; i < 4; i++) ref_bytes[{addr[7:2], 2'b00} + i] = word[8*i +: 8];
   endtask

   function automatic logic [31:0] ref_word(input int w);
      return {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]};
   endfunction

   task automatic push(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
      pend_q.push_back('{we: we, size: size, uns: uns, addr: addr, wdata: wdata});
   endtask

   // Reference behaviour: natural alignment, little-endian bytes, arithmetic extension.
   task automatic ref_apply(input req_t r, output exp_t e);
      int          nb;
      int          base;
      logic [31:0] v;
      nb      = 1 << r.size;
      base    = int'(r.addr);
      e.waddr = {r.addr[31:2], 2'b00};
      e.rdata = '0;
      e.wes   = 0;
      e.err   = (r.size == 2'b11) || ((base % nb) != 0);
      if (e.err) begin
         e.lat = 0;
      end else if (r.we) begin
         for (int i = 0; i < nb; i++) ref_bytes[base + i] = r.wdata[8*i +: 8];
         e.lat = (nb == 4) ? 1 : 2;
         e.wes = 1;
      end else begin
         v = '0;
         for (int i = 0; i < nb; i++) v = v | (32'(ref_bytes[base + i]) << (8*i));
         if (!r.uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
         e.rdata = v;
         e.lat   = 1;
      end
   endtask

   // Presents pend_q with req_valid held; entered and left just after a rising edge.
   task automatic run_batch();
      int   n, sent, got, budget, wes;
      logic acc;
      exp_t e, cur;
      n = pend_q.size();
      sent = 0; got = 0; budget = 0; wes = 0;
      rsp_log.delete();
      while (got < n && budget < 20*n + 20) begin
         if (sent < n) begin
            req_we       = pend_q[sent].we;
            req_size     = pend_q[sent].size;
            req_unsigned = pend_q[sent].uns;
            req_addr     = pend_q[sent].addr;
            req_wdata    = pend_q[sent].wdata;
            req_valid    = 1'b1;
         end else begin
            req_valid = 1'b0;
         end
         @(negedge clk);
         if (!mem_we) chk("wdata_idle_zero", mem_wdata, 32'h0);
         if (exp_q.size() > 0) begin
            chk("busy_ready", {31'b0, req_ready}, 32'h0);
            if (mem_we) begin
               wes++;
               chk("we_addr", mem_addr, exp_q[0].waddr);
            end
            if (rsp_valid) begin
               cur = exp_q.pop_front();
               rsp_log.push_back(rsp_rdata);
               chk("rsp_rdata", rsp_rdata, cur.rdata);
               chk("rsp_err", {31'b0, rsp_err}, {31'b0, cur.err});
               chk("latency", cyc - cur.acc_cyc, cur.lat);
               chk("we_cycles", wes, cur.wes);
               wes = 0;
               got++;
            end
         end else begin
            chk("idle_ready", {31'b0, req_ready}, 32'h1);
            chk("stray_we", {31'b0, mem_we}, 32'h0);
            chk("stray_rsp", {31'b0, rsp_valid}, 32'h0);
         end
         acc = req_valid && req_ready;
         @(posedge clk);
         cyc++;
         budget++;
         if (acc) begin
            ref_apply(pend_q[sent], e);
            e.acc_cyc = cyc;
            exp_q.push_back(e);
            sent++;
         end
         #1;
      end
      req_valid = 1'b0;
      if (got < n) chk("batch_timeout", got, n);
      pend_q.delete();
      exp_q.delete();
   endtask

   task automatic check_mem();
      for (int w = 0; w < NWORDS; w++) chk("mem_word", tb_mem[w], ref_word(w));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = '0; req_wdata = '0;
      for (int w = 0; w < NWORDS; w++) preload(32'(4*w), $urandom);

      repeat (2) @(negedge clk);
      chk("rst_ready", {31'b0, req_ready}, 32'h0);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
      rst_n = 1'b1;
      #1 chk("ready_after_rst", {31'b0, req_ready}, 32'h1);
      @(posedge clk); #1;

      push(1, 2'b10, 0, 32'h10, 32'hDEAD_BEEF);
      push(0, 2'b10, 0, 32'h10, 32'h0);
      run_batch();
      chk("sw_lw_data", rsp_log[1], 32'hDEAD_BEEF);
      chk("sw_mem", tb_mem[32'h10 >> 2], 32'hDEAD_BEEF);

      preload(32'h20, 32'h80FF_7F01);
      push(0, 2'b00, 0, 32'h23, 32'h0);
      push(0, 2'b00, 1, 32'h23, 32'h0);
      push(0, 2'b01, 0, 32'h22, 32'h0);
      push(0, 2'b01, 1, 32'h20, 32'h0);
      run_batch();
      chk("lb", rsp_log[0], 32'hFFFF_FF80);
      chk("lbu", rsp_log[1], 32'h0000_0080);
      chk("lh", rsp_log[2], 32'hFFFF_80FF);
      chk("lhu", rsp_log[3], 32'h0000_7F01);

      preload(32'h20, 32'h1122_3344);
      push(1, 2'b00, 0, 32'h21, 32'h0000_00AA);
      run_batch();
      chk("sb_mem", tb_mem[32'h20 >> 2], 32'h1122_AA44);
      push(1, 2'b01, 0, 32'h22, 32'h1234_BEEF);
      run_batch();
      chk("sh_mem", tb_mem[32'h20 >> 2], 32'hBEEF_AA44);

      push(0, 2'b10, 0, 32'h12, 32'h0);
      push(1, 2'b01, 0, 32'h31, 32'hFFFF_FFFF);
      push(1, 2'b11, 0, 32'h40, 32'hFFFF_FFFF);
      push(0, 2'b11, 1, 32'h44, 32'h0);
      run_batch();
      check_mem();

      push(0, 2'b10, 0, 32'h10, 32'h0);
      push(1, 2'b00, 0, 32'h13, 32'h0000_0055);
      push(0, 2'b01, 1, 32'h12, 32'h0);
      run_batch();
      chk("b2b_lhu", rsp_log[2], 32'h0000_55AD);

      for (int it = 0; it < 30; it++) begin
         int nreq;
         nreq = $urandom_range(1, 3);
         for (int k = 0; k < nreq; k++) begin
            logic [1:0]  sz;
            logic [31:0] ad;
            sz = 2'($urandom_range(0, 3));
            ad = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0 && sz != 2'b11) ad = ad & ~((32'h1 << sz) - 1);
            push(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom);
         end
         run_batch();
      end
      check_mem();

      preload(32'h30, 32'hCAFE_F00D);
      req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 32'h31; req_wdata = 32'h0000_0077; req_valid = 1'b1;
      @(negedge clk);
      chk("rmw_rst_ready", {31'b0, req_ready}, 32'h1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_we", {31'b0, mem_we}, 32'h0);
      chk("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
      chk("mid_rst_ready", {31'b0, req_ready}, 32'h0);
      chk("mid_rst_mem_addr", mem_addr, 32'h0);
      chk("mid_rst_mem_wdata", mem_wdata, 32'h0);
      chk("mid_rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("mid_rst_rsp_err", {31'b0, rsp_err}, 32'h0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("rst_hold_we", {31'b0, mem_we}, 32'h0);
         chk("rst_hold_rsp", {31'b0, rsp_valid}, 32'h0);
      end
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("post_rst_rsp", {31'b0, rsp_valid}, 32'h0);
         chk("post_rst_ready", {31'b0, req_ready}, 32'h1);
      end
      chk("rmw_rst_word", tb_mem[32'h30 >> 2], 32'hCAFE_F00D);
      @(posedge clk); #1;
      push(1, 2'b00, 0, 32'h32, 32'h0000_0011);
      run_batch();
      chk("post_rst_sb", tb_mem[32'h30 >> 2], 32'hCA11_F00D);
      check_mem();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
